// File: rtl/apb_rx.sv
// apb_rx: UART receiver paired with apb_tx.
// Mid-bit sampling with latched mode/baud and stop-bit error flag.
module apb_rx #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        sel,
    input  logic        set,
    input  logic        mode,
    input  logic [19:0] baud,
    input  logic        rx_in,
    output logic [9:0]  dout,
    output logic        rx_valid,
    output logic        frame_err,
    output logic        rx_busy
);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t state, state_nx;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;
    logic                   rx_prev;
    logic                   mode_r;
    logic [19:0]            baud_r;
    logic [19:0]            b_eff;
    logic [19:0]            half_m1;
    logic [19:0]            full_m1;
    logic [19:0]            cnt;
    logic [3:0]             bit_idx;
    logic [9:0]             shreg;
    logic                   en;
    logic                   last_bit;
    logic                   take;
    logic                   good;
    logic                   bad;
    logic                   restart;

    assign rx_s     = sync_q[SYNC_STAGES-1];
    assign en       = sel & set;
    assign b_eff    = (baud_r < 20'd4) ? 20'd4 : baud_r;
    assign half_m1  = (b_eff >> 1) - 20'd1;
    assign full_m1  = b_eff - 20'd1;
    assign last_bit = (bit_idx == (mode_r ? 4'd9 : 4'd7));
    assign rx_busy  = (state != IDLE);

    always_comb begin
        state_nx = state;
        take     = 1'b0;
        good     = 1'b0;
        bad      = 1'b0;
        if (!en) begin
            state_nx = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (rx_prev && !rx_s)
                        state_nx = START;
                end
                START: begin
                    if (cnt == half_m1)
                        state_nx = rx_s ? IDLE : DATA;
                end
                DATA: begin
                    if (cnt == full_m1) begin
                        take = 1'b1;
                        if (last_bit)
                            state_nx = STOP;
                    end
                end
                STOP: begin
                    if (cnt == full_m1) begin
                        state_nx = IDLE;
                        good     = rx_s;
                        bad      = !rx_s;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    // Counter restarts on every state change and after each data sample.
    assign restart = (state_nx != state) || take;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_q    <= '1;
            rx_prev   <= 1'b1;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            mode_r    <= 1'b0;
            baud_r    <= '0;
            dout      <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], rx_in};
            rx_prev   <= rx_s;
            cnt       <= restart ? 20'd0 : cnt + 20'd1;
            rx_valid  <= good;
            frame_err <= bad;
            if (sel && !set) begin
                mode_r <= mode;
                baud_r <= baud;
            end
            if (state == START)
                bit_idx <= '0;
            else if (take)
                bit_idx <= bit_idx + 4'd1;
            if (take)
                shreg[bit_idx] <= rx_s;
            if (good)
                dout <= mode_r ? shreg : {2'b00, shreg[7:0]};
        end
    end

endmodule

// File: tb/tb_apb_rx.sv
// tb_apb_rx: randomized frames against a frame-level model.
// Expected strobes are queued by the driver and popped by a monitor.
module tb_apb_rx;

    localparam int SYNC = 2;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        sel = 1'b0;
    logic        set = 1'b0;
    logic        mode = 1'b0;
    logic [19:0] baud = '0;
    logic        rx_in = 1'b1;
    logic [9:0]  dout;
    logic        rx_valid;
    logic        frame_err;
    logic        rx_busy;

    apb_rx #(.SYNC_STAGES(SYNC)) dut (
        .clk(clk),
        .rstn(rstn),
        .sel(sel),
        .set(set),
        .mode(mode),
        .baud(baud),
        .rx_in(rx_in),
        .dout(dout),
        .rx_valid(rx_valid),
        .frame_err(frame_err),
        .rx_busy(rx_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         is_valid;
        logic [9:0] word;
        int         t0;
        int         lat;
    } exp_t;

    exp_t       sbq[$];
    logic [9:0] last_good = '0;
    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;

    always @(posedge clk) cyc++;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        int   lat;
        if (rstn && (rx_valid || frame_err)) begin
            if (sbq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_strobe: rx_valid=%0b frame_err=%0b dout=%0h, none expected",
                         rx_valid, frame_err, dout);
            end else begin
                e = sbq.pop_front();
                chk("strobe_kind", {30'd0, rx_valid, frame_err},
                    e.is_valid ? 32'd2 : 32'd1);
                chk("dout", {22'd0, dout}, {22'd0, e.word});
                lat = cyc - e.t0;
                checks++;
                if (lat < e.lat - 1 || lat > e.lat + 1) begin
                    failures++;
                    $display("FAIL latency: got %0d cycles expected %0d +-1", lat, e.lat);
                end
            end
        end
    end

    function automatic int beff(int b);
        return (b < 4) ? 4 : b;
    endfunction

    task automatic configure(int b, bit m);
        @(negedge clk);
        sel  = 1'b1;
        set  = 1'b0;
        baud = b[19:0];
        mode = m;
        @(negedge clk);
        set = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic drive_bits(logic [9:0] d, int n, int bt);
        for (int i = 0; i < n; i++) begin
            rx_in = d[i];
            repeat (bt) @(negedge clk);
        end
    endtask

    task automatic send_frame(logic [9:0] d, bit m, int b, bit stop, int hold_low);
        exp_t e;
        int   bt;
        int   n;
        bt = beff(b);
        n  = m ? 10 : 8;
        if (stop) begin
            last_good  = m ? d : {2'b00, d[7:0]};
            e.is_valid = 1'b1;
        end else begin
            e.is_valid = 1'b0;
        end
        e.word = last_good;
        e.t0   = cyc;
        e.lat  = bt / 2 + (n + 1) * bt + SYNC + 1;
        sbq.push_back(e);
        rx_in = 1'b0;
        repeat (bt) @(negedge clk);
        drive_bits(d, n, bt);
        rx_in = stop;
        repeat (bt) @(negedge clk);
        if (hold_low > 0) begin
            rx_in = 1'b0;
            repeat (hold_low) @(negedge clk);
        end
        rx_in = 1'b1;
        repeat (2 * bt + 4) @(negedge clk);
        chk("drain", sbq.size(), 0);
        sbq.delete();
    endtask

    task automatic send_partial(logic [9:0] d, int b, int nbits);
        int bt;
        bt = beff(b);
        rx_in = 1'b0;
        repeat (bt) @(negedge clk);
        drive_bits(d, nbits, bt);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cleared;
        repeat (3) @(negedge clk);
        chk("rst_dout", {22'd0, dout}, 0);
        chk("rst_valid", {31'd0, rx_valid}, 0);
        chk("rst_ferr", {31'd0, frame_err}, 0);
        chk("rst_busy", {31'd0, rx_busy}, 0);
        rstn = 1'b1;

        configure(16, 1'b0);
        send_frame(10'h035, 1'b0, 16, 1'b1, 0);
        chk("hold_035", {22'd0, dout}, 32'h035);

        configure(20, 1'b1);
        send_frame(10'b11000_01010, 1'b1, 20, 1'b1, 0);
        chk("hold_30a", {22'd0, dout}, 32'h30A);

        configure(16, 1'b0);
        send_frame(10'h0A5, 1'b0, 16, 1'b0, 100);
        chk("break_dout", {22'd0, dout}, {22'd0, last_good});
        repeat (20) @(negedge clk);

        rx_in = 1'b0;
        repeat (3) @(negedge clk);
        rx_in = 1'b1;
        chk("glitch_busy_set", {31'd0, rx_busy}, 1);
        cleared = 0;
        for (int k = 0; k < 8 && !cleared; k++) begin
            @(negedge clk);
            if (!rx_busy) cleared = 1;
        end
        chk("glitch_busy_clear", cleared, 1);
        repeat (30) @(negedge clk);

        send_partial(10'h03C, 16, 4);
        chk("abort_busy_before", {31'd0, rx_busy}, 1);
        set   = 1'b0;
        rx_in = 1'b1;
        @(negedge clk);
        chk("abort_busy_after", {31'd0, rx_busy}, 0);
        repeat (200) @(negedge clk);
        configure(16, 1'b0);
        send_frame(10'h05A, 1'b0, 16, 1'b1, 0);
        chk("after_abort", {22'd0, dout}, 32'h05A);

        send_partial(10'h0C3, 16, 3);
        #2;
        rstn = 1'b0;
        #1;
        chk("arst_dout", {22'd0, dout}, 0);
        chk("arst_busy", {31'd0, rx_busy}, 0);
        chk("arst_valid", {31'd0, rx_valid}, 0);
        chk("arst_ferr", {31'd0, frame_err}, 0);
        last_good = '0;
        rx_in = 1'b1;
        sbq.delete();
        @(negedge clk);
        rstn = 1'b1;
        configure(16, 1'b0);
        send_frame(10'h0FF, 1'b0, 16, 1'b1, 0);
        chk("after_rst", {22'd0, dout}, 32'h0FF);

        for (int it = 0; it < 24; it++) begin
            int         b;
            bit         m;
            bit         stp;
            logic [9:0] d;
            b   = $urandom_range(0, 24);
            m   = 1'($urandom_range(0, 1));
            stp = ($urandom_range(0, 4) != 0);
            d   = 10'($urandom_range(0, 1023));
            configure(b, m);
            send_frame(d, m, b, stp, 0);
            chk("rand_dout", {22'd0, dout}, {22'd0, last_good});
        end

        repeat (10) @(negedge clk);
        chk("queue_empty", sbq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
